// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One product/quotient bit per RUN cycle; MTHI/MTLO write HI/LO directly from idle.
module mdu_hilo #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mdu_a,
  input  logic [31:0] mdu_b,
  input  logic [2:0]  mdu_op,
  input  logic        mdu_start,
  input  logic        mdu_cancel,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] mdu_hi,
  output logic [31:0] mdu_lo
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_mag_q, b_mag_d;
  logic [63:0]     work_q, work_d;
  logic            done_q, done_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic            signed_op;
  logic [31:0]     a_mag, b_mag;
  logic [32:0]     msum;
  logic [63:0]     mul_next;
  logic [32:0]     rem_sh;
  logic [33:0]     diff;
  logic [63:0]     div_next;
  logic [63:0]     step;
  logic [63:0]     prod;
  logic [31:0]     quo, rem;

  always_comb begin
    signed_op = ~mdu_op[0];
    a_mag = (signed_op && mdu_a[31]) ? (~mdu_a + 32'd1) : mdu_a;
    b_mag = (signed_op && mdu_b[31]) ? (~mdu_b + 32'd1) : mdu_b;

    // work holds {partial product, remaining multiplier bits}
    msum     = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_mag_q} : 33'd0);
    mul_next = {msum, work_q[31:1]};

    // work holds {partial remainder, dividend bits / quotient bits}
    rem_sh   = work_q[63:31];
    diff     = {1'b0, rem_sh} - {2'b00, b_mag_q};
    div_next = diff[33] ? {rem_sh[31:0], work_q[30:0], 1'b0}
                        : {diff[31:0], work_q[30:0], 1'b1};

    step = is_div_q ? div_next : mul_next;
    prod = neg_q ? (~step + 64'd1) : step;
    quo  = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
    rem  = rem_neg_q ? (~step[63:32] + 32'd1) : step[63:32];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    a_d       = a_q;
    b_mag_d   = b_mag_q;
    work_d    = work_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (state_q == StIdle) begin
      if (mdu_start && !mdu_cancel) begin
        case (mdu_op)
          OpMult, OpMultu, OpDiv, OpDivu: begin
            state_d   = StRun;
            cnt_d     = '0;
            is_div_d  = mdu_op[1];
            neg_d     = signed_op & (mdu_a[31] ^ mdu_b[31]);
            rem_neg_d = signed_op & mdu_a[31];
            a_d       = mdu_a;
            b_mag_d   = b_mag;
            work_d    = {32'd0, a_mag};
          end
          OpMthi:  hi_d = mdu_a;
          OpMtlo:  lo_d = mdu_a;
          default: ;
        endcase
      end
    end else begin
      if (mdu_cancel) begin
        state_d = StIdle;
      end else begin
        work_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod;
          end else if (b_mag_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_q       <= '0;
      b_mag_q   <= '0;
      work_q    <= '0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      a_q       <= a_d;
      b_mag_q   <= b_mag_d;
      work_q    <= work_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mdu_busy = (state_q == StRun);
  assign mdu_done = done_q;
  assign mdu_hi   = hi_q;
  assign mdu_lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed vector table, random ops against an
// arithmetic reference model, and hand-written cancel/reset/ignored-start sequences.
module tb_mdu_hilo;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mdu_a, mdu_b;
  logic [2:0]  mdu_op;
  logic        mdu_start, mdu_cancel;
  logic        mdu_busy, mdu_done;
  logic [31:0] mdu_hi, mdu_lo;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] hi_m, lo_m;

  mdu_hilo #(.ITER(ITER)) dut (
    .clk        (clk),
    .reset      (reset),
    .mdu_a      (mdu_a),
    .mdu_b      (mdu_b),
    .mdu_op     (mdu_op),
    .mdu_start  (mdu_start),
    .mdu_cancel (mdu_cancel),
    .mdu_busy   (mdu_busy),
    .mdu_done   (mdu_done),
    .mdu_hi     (mdu_hi),
    .mdu_lo     (mdu_lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      3'd2: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'd0; lo = a; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Called just after a negedge; leaves the bench at the negedge of the done cycle.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input string name);
    mdu_start = 1'b1; mdu_op = op; mdu_a = a; mdu_b = b;
    @(negedge clk);
    mdu_start = 1'b0;
    for (int i = 0; i < ITER; i++) begin
      chk({name, "_busy"}, {31'd0, mdu_busy}, 32'd1);
      chk({name, "_nodone"}, {31'd0, mdu_done}, 32'd0);
      if (i < ITER - 1) @(negedge clk);
    end
    @(negedge clk);
    chk({name, "_done"}, {31'd0, mdu_done}, 32'd1);
    chk({name, "_idle"}, {31'd0, mdu_busy}, 32'd0);
    chk({name, "_hi"}, mdu_hi, exp_hi);
    chk({name, "_lo"}, mdu_lo, exp_lo);
    hi_m = exp_hi;
    lo_m = exp_lo;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input string name);
    mdu_start = 1'b1; mdu_op = op; mdu_a = a; mdu_b = 32'd0;
    @(negedge clk);
    mdu_start = 1'b0;
    if (op == 3'b100) hi_m = a;
    else lo_m = a;
    chk({name, "_busy"}, {31'd0, mdu_busy}, 32'd0);
    chk({name, "_done"}, {31'd0, mdu_done}, 32'd0);
    chk({name, "_hi"}, mdu_hi, hi_m);
    chk({name, "_lo"}, mdu_lo, lo_m);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, rhi, rlo;
    logic        seen_done;

    reset = 1'b0; mdu_a = '0; mdu_b = '0; mdu_op = '0; mdu_start = 1'b0; mdu_cancel = 1'b0;
    hi_m = '0; lo_m = '0;

    tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    tbl[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("rst_done", {31'd0, mdu_done}, 32'd0);
    chk("rst_hi", mdu_hi, 32'd0);
    chk("rst_lo", mdu_lo, 32'd0);

    // Release reset together with a start: first rising edge must accept it.
    reset = 1'b1;
    do_mt(3'b100, 32'hA5A5_0001, "first_mthi");
    do_mt(3'b101, 32'h5A5A_0002, "mtlo");

    for (int i = 0; i < 8; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));
    @(negedge clk);
    chk("done_one_cycle", {31'd0, mdu_done}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ref_model(rop, ra, rb, rhi, rlo);
      do_op(rop, ra, rb, rhi, rlo, $sformatf("rnd%0d", i));
    end
    @(negedge clk);

    // Cancel a DIVU at E+10, then MTLO.
    mdu_start = 1'b1; mdu_op = 3'd3; mdu_a = 32'd1000; mdu_b = 32'd3;
    @(negedge clk);
    mdu_start = 1'b0;
    repeat (8) @(negedge clk);
    mdu_cancel = 1'b1;
    @(negedge clk);
    mdu_cancel = 1'b0;
    chk("cancel_busy", {31'd0, mdu_busy}, 32'd0);
    do_mt(3'b101, 32'd5, "cancel_mtlo");
    seen_done = 1'b0;
    repeat (ITER) begin
      @(negedge clk);
      seen_done |= mdu_done;
    end
    chk("cancel_no_done", {31'd0, seen_done}, 32'd0);
    chk("cancel_hi", mdu_hi, hi_m);

    // Cancel in idle blocks MTHI; undefined op is a NOP.
    mdu_cancel = 1'b1; mdu_start = 1'b1; mdu_op = 3'b100; mdu_a = 32'hDEAD_BEEF;
    @(negedge clk);
    mdu_cancel = 1'b0; mdu_start = 1'b0;
    chk("idle_cancel_hi", mdu_hi, hi_m);
    mdu_start = 1'b1; mdu_op = 3'b110; mdu_a = 32'hCAFE_0000; mdu_b = 32'd9;
    @(negedge clk);
    mdu_start = 1'b0;
    chk("nop_busy", {31'd0, mdu_busy}, 32'd0);
    chk("nop_hi", mdu_hi, hi_m);
    chk("nop_lo", mdu_lo, lo_m);

    // Second start at E+5 must be ignored.
    mdu_start = 1'b1; mdu_op = 3'd0; mdu_a = 32'd7; mdu_b = 32'hFFFF_FFFD;
    @(negedge clk);
    mdu_start = 1'b0;
    repeat (3) @(negedge clk);
    mdu_start = 1'b1; mdu_op = 3'd1; mdu_a = 32'd100; mdu_b = 32'd100;
    @(negedge clk);
    mdu_start = 1'b0;
    repeat (ITER - 5) @(negedge clk);
    chk("ign_busy_last", {31'd0, mdu_busy}, 32'd1);
    @(negedge clk);
    chk("ign_done", {31'd0, mdu_done}, 32'd1);
    chk("ign_hi", mdu_hi, 32'hFFFF_FFFF);
    chk("ign_lo", mdu_lo, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("ign_idle", {31'd0, mdu_busy}, 32'd0);

    // Reset mid-RUN at E+15.
    mdu_start = 1'b1; mdu_op = 3'd1; mdu_a = 32'h0000_FFFF; mdu_b = 32'h0000_FFFF;
    @(negedge clk);
    mdu_start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, mdu_busy}, 32'd0);
    chk("arst_hi", mdu_hi, 32'd0);
    chk("arst_lo", mdu_lo, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    repeat (ITER + 4) begin
      @(negedge clk);
      seen_done |= mdu_done;
    end
    chk("arst_no_done", {31'd0, seen_done}, 32'd0);

    // Back-to-back issue in the done cycle.
    do_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, "b2b_a");
    do_op(3'd3, 32'd17, 32'd5, 32'd2, 32'd3, "b2b_b");
    @(negedge clk);
    chk("b2b_end_done", {31'd0, mdu_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
